// File: rtl/foxtrot_pkg.sv
// Shared types and sizing for the rename slice. RENAME_XZR_EN makes arch NUM_ARCH-1 a zero register.
// Widths derive from NUM_ARCH/NUM_PHYS; MAX_IO must match the free list lane count.
package foxtrot_pkg;
  localparam int NUM_ARCH = 32;
  localparam int NUM_PHYS = 64;
  localparam int MAX_IO   = 3;
  localparam int AW       = $clog2(NUM_ARCH);
  localparam int PW       = $clog2(NUM_PHYS);

  typedef logic [AW-1:0] arch_reg_t;
  typedef logic [PW-1:0] preg_t;
  typedef logic [PW:0]   fl_len_t;

  typedef struct packed {
    logic      dst_en;
    arch_reg_t dst;
    arch_reg_t src1;
    arch_reg_t src2;
  } rename_op_t;

`ifdef RENAME_XZR_EN
  localparam bit XZR_EN = 1'b1;
`else
  localparam bit XZR_EN = 1'b0;
`endif

  localparam arch_reg_t XZR_ARCH = arch_reg_t'(NUM_ARCH - 1);
  localparam preg_t     XZR_PREG = preg_t'(NUM_ARCH - 1);

  function automatic logic is_xzr(input arch_reg_t a);
    return XZR_EN && (a == XZR_ARCH);
  endfunction
endpackage

// File: rtl/rename_stage_if.sv
// Rename stage bundle: decode input, renamed output, free-list and commit/squash ports.
// slave is the rename stage side, master the surrounding pipeline / free list side.
interface rename_stage_if;
  import foxtrot_pkg::*;

  logic [MAX_IO-1:0]      in_valid;
  logic [MAX_IO-1:0]      in_dst_en;
  arch_reg_t [MAX_IO-1:0] in_dst;
  arch_reg_t [MAX_IO-1:0] in_src1;
  arch_reg_t [MAX_IO-1:0] in_src2;
  logic                   in_ready;
  logic [MAX_IO-1:0]      out_valid;
  preg_t [MAX_IO-1:0]     out_pdst;
  preg_t [MAX_IO-1:0]     out_psrc1;
  preg_t [MAX_IO-1:0]     out_psrc2;
  preg_t [MAX_IO-1:0]     out_pold;
  logic                   out_ready;
  fl_len_t                fl_len;
  logic [MAX_IO-1:0]      fl_get_en;
  preg_t [MAX_IO-1:0]     fl_gotten;
  logic [MAX_IO-1:0]      fl_put_en;
  preg_t [MAX_IO-1:0]     fl_put;
  fl_len_t                fl_rst_skip;
  logic [MAX_IO-1:0]      cm_en;
  arch_reg_t [MAX_IO-1:0] cm_dst;
  preg_t [MAX_IO-1:0]     cm_pdst;
  logic [MAX_IO-1:0]      sq_en;
  preg_t [MAX_IO-1:0]     sq_preg;
  logic                   flush;

  modport slave (
    input  in_valid, in_dst_en, in_dst, in_src1, in_src2, out_ready, fl_len, fl_gotten,
           cm_en, cm_dst, cm_pdst, sq_en, sq_preg, flush,
    output in_ready, out_valid, out_pdst, out_psrc1, out_psrc2, out_pold,
           fl_get_en, fl_put_en, fl_put, fl_rst_skip
  );

  modport master (
    output in_valid, in_dst_en, in_dst, in_src1, in_src2, out_ready, fl_len, fl_gotten,
           cm_en, cm_dst, cm_pdst, sq_en, sq_preg, flush,
    input  in_ready, out_valid, out_pdst, out_psrc1, out_psrc2, out_pold,
           fl_get_en, fl_put_en, fl_put, fl_rst_skip
  );
endinterface

// File: rtl/rename_bypass.sv
// Intra-group dependency resolution: a lane's sources/old-dest take the pdst of the latest
// earlier lane writing the same arch reg, else the spec RAT value. Purely combinational.
module rename_bypass
  import foxtrot_pkg::*;
(
  input  logic [MAX_IO-1:0]       valid_i,
  input  rename_op_t [MAX_IO-1:0] op_i,
  input  preg_t [MAX_IO-1:0]      gotten_i,
  input  preg_t [MAX_IO-1:0]      rat_src1_i,
  input  preg_t [MAX_IO-1:0]      rat_src2_i,
  input  preg_t [MAX_IO-1:0]      rat_dst_i,
  output logic [MAX_IO-1:0]       wr_o,
  output preg_t [MAX_IO-1:0]      pdst_o,
  output preg_t [MAX_IO-1:0]      psrc1_o,
  output preg_t [MAX_IO-1:0]      psrc2_o,
  output preg_t [MAX_IO-1:0]      pold_o
);
  always_comb begin
    wr_o   = '0;
    pdst_o = gotten_i;
    for (int i = 0; i < MAX_IO; i++) begin
      wr_o[i] = valid_i[i] && op_i[i].dst_en && !is_xzr(op_i[i].dst);
      if (is_xzr(op_i[i].dst)) pdst_o[i] = XZR_PREG;
    end
  end

  // Ascending j: the last matching earlier lane overrides, i.e. the youngest producer wins.
  always_comb begin
    psrc1_o = rat_src1_i;
    psrc2_o = rat_src2_i;
    pold_o  = rat_dst_i;
    for (int i = 0; i < MAX_IO; i++) begin
      for (int j = 0; j < i; j++) begin
        if (wr_o[j] && op_i[j].dst == op_i[i].src1) psrc1_o[i] = gotten_i[j];
        if (wr_o[j] && op_i[j].dst == op_i[i].src2) psrc2_o[i] = gotten_i[j];
        if (wr_o[j] && op_i[j].dst == op_i[i].dst)  pold_o[i]  = gotten_i[j];
      end
    end
  end
endmodule

// File: rtl/rename_stage.sv
// Register rename with spec/committed RATs; one-cycle registered output, whole group stalls on
// downstream backpressure, flush or a short free list. RENAME_XZR_EN enables the zero register.
module rename_stage
  import foxtrot_pkg::*;
(
  input logic           clk,
  input logic           rst,
  rename_stage_if.slave rif
);
  preg_t spec_rat_q [NUM_ARCH];
  preg_t spec_rat_d [NUM_ARCH];
  preg_t cm_rat_q   [NUM_ARCH];
  preg_t cm_rat_d   [NUM_ARCH];

  rename_op_t [MAX_IO-1:0] op;
  preg_t [MAX_IO-1:0]      rat_src1, rat_src2, rat_dst;
  preg_t [MAX_IO-1:0]      pdst, psrc1, psrc2, pold;
  logic [MAX_IO-1:0]       wr;
  fl_len_t                 need;
  logic                    in_ready, accept;
  logic [MAX_IO-1:0]       put_en;
  preg_t [MAX_IO-1:0]      put;

  logic [MAX_IO-1:0]  out_valid_q;
  preg_t [MAX_IO-1:0] out_pdst_q, out_psrc1_q, out_psrc2_q, out_pold_q;

  always_comb begin
    op = '0;
    for (int i = 0; i < MAX_IO; i++) begin
      op[i] = '{dst_en: rif.in_dst_en[i], dst: rif.in_dst[i],
                src1: rif.in_src1[i], src2: rif.in_src2[i]};
    end
  end

  always_comb begin
    rat_src1 = '0;
    rat_src2 = '0;
    rat_dst  = '0;
    for (int i = 0; i < MAX_IO; i++) begin
      rat_src1[i] = spec_rat_q[rif.in_src1[i]];
      rat_src2[i] = spec_rat_q[rif.in_src2[i]];
      rat_dst[i]  = spec_rat_q[rif.in_dst[i]];
    end
  end

  rename_bypass u_bypass (
    .valid_i   (rif.in_valid),
    .op_i      (op),
    .gotten_i  (rif.fl_gotten),
    .rat_src1_i(rat_src1),
    .rat_src2_i(rat_src2),
    .rat_dst_i (rat_dst),
    .wr_o      (wr),
    .pdst_o    (pdst),
    .psrc1_o   (psrc1),
    .psrc2_o   (psrc2),
    .pold_o    (pold)
  );

  always_comb begin
    need = '0;
    for (int i = 0; i < MAX_IO; i++) need = need + fl_len_t'(wr[i]);
  end

  assign in_ready = rst && !rif.flush && (out_valid_q == '0 || rif.out_ready) && (rif.fl_len >= need);
  assign accept   = in_ready && (|rif.in_valid);

  // Commits walk lanes in order so a later lane on the same arch reg frees the earlier lane's preg.
  always_comb begin
    cm_rat_d = cm_rat_q;
    put_en   = '0;
    put      = '0;
    for (int i = 0; i < MAX_IO; i++) begin
      if (rif.cm_en[i]) begin
        if (!is_xzr(rif.cm_dst[i])) begin
          put_en[i] = 1'b1;
          put[i]    = cm_rat_d[rif.cm_dst[i]];
          cm_rat_d[rif.cm_dst[i]] = rif.cm_pdst[i];
        end
      end else if (rif.sq_en[i]) begin
        put_en[i] = 1'b1;
        put[i]    = rif.sq_preg[i];
      end
    end
    if (!rst) put_en = '0;
  end

  always_comb begin
    spec_rat_d = spec_rat_q;
    if (rif.flush) begin
      spec_rat_d = cm_rat_d;
    end else if (accept) begin
      for (int i = 0; i < MAX_IO; i++) begin
        if (wr[i]) spec_rat_d[op[i].dst] = pdst[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int a = 0; a < NUM_ARCH; a++) begin
        spec_rat_q[a] <= preg_t'(a);
        cm_rat_q[a]   <= preg_t'(a);
      end
      out_valid_q <= '0;
    end else begin
      spec_rat_q <= spec_rat_d;
      cm_rat_q   <= cm_rat_d;
      if (rif.flush)          out_valid_q <= '0;
      else if (accept)        out_valid_q <= rif.in_valid;
      else if (rif.out_ready) out_valid_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      out_pdst_q  <= pdst;
      out_psrc1_q <= psrc1;
      out_psrc2_q <= psrc2;
      out_pold_q  <= pold;
    end
  end

  assign rif.in_ready    = in_ready;
  assign rif.out_valid   = out_valid_q;
  assign rif.out_pdst    = out_pdst_q;
  assign rif.out_psrc1   = out_psrc1_q;
  assign rif.out_psrc2   = out_psrc2_q;
  assign rif.out_pold    = out_pold_q;
  assign rif.fl_get_en   = wr & {MAX_IO{in_ready}};
  assign rif.fl_put_en   = put_en;
  assign rif.fl_put      = put;
  assign rif.fl_rst_skip = fl_len_t'(NUM_ARCH);
endmodule

// File: tb/tb_rename_stage.sv
// Directed bench for rename_stage: expected output groups queue up at acceptance and a monitor
// compares them when the output handshake fires; combinational outputs are checked inline.
module tb_rename_stage;
  import foxtrot_pkg::*;

  typedef struct packed {
    logic [MAX_IO-1:0]  v;
    preg_t [MAX_IO-1:0] pdst;
    preg_t [MAX_IO-1:0] ps1;
    preg_t [MAX_IO-1:0] ps2;
    preg_t [MAX_IO-1:0] pold;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t cur;

  rename_stage_if ifc ();

  rename_stage dut (.clk(clk), .rst(rst), .rif(ifc.slave));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    ifc.in_valid  = '0;
    ifc.in_dst_en = '0;
    ifc.in_dst    = '0;
    ifc.in_src1   = '0;
    ifc.in_src2   = '0;
    ifc.out_ready = 1'b1;
    ifc.fl_len    = fl_len_t'(32);
    ifc.fl_gotten = '0;
    ifc.cm_en     = '0;
    ifc.cm_dst    = '0;
    ifc.cm_pdst   = '0;
    ifc.sq_en     = '0;
    ifc.sq_preg   = '0;
    ifc.flush     = 1'b0;
  endtask

  task automatic op(input int i, input int d, input int s1, input int s2, input int g);
    ifc.in_valid[i]  = 1'b1;
    ifc.in_dst_en[i] = 1'b1;
    ifc.in_dst[i]    = arch_reg_t'(d);
    ifc.in_src1[i]   = arch_reg_t'(s1);
    ifc.in_src2[i]   = arch_reg_t'(s2);
    ifc.fl_gotten[i] = preg_t'(g);
  endtask

  task automatic lane(input int i, input int pd, input int s1, input int s2, input int po);
    cur.v[i]    = 1'b1;
    cur.pdst[i] = preg_t'(pd);
    cur.ps1[i]  = preg_t'(s1);
    cur.ps2[i]  = preg_t'(s2);
    cur.pold[i] = preg_t'(po);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
    cur = '0;
  endtask

  // Monitor: compare every output group that is actually taken downstream.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && ifc.out_valid != '0 && ifc.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: out_valid=%b with nothing expected (t=%0t)", ifc.out_valid, $time);
        end else begin
          e = sb.pop_front();
          chk("out_valid", 32'(ifc.out_valid), 32'(e.v));
          for (int i = 0; i < MAX_IO; i++) begin
            if (e.v[i]) begin
              chk($sformatf("out_pdst[%0d]", i),  32'(ifc.out_pdst[i]),  32'(e.pdst[i]));
              chk($sformatf("out_psrc1[%0d]", i), 32'(ifc.out_psrc1[i]), 32'(e.ps1[i]));
              chk($sformatf("out_psrc2[%0d]", i), 32'(ifc.out_psrc2[i]), 32'(e.ps2[i]));
              chk($sformatf("out_pold[%0d]", i),  32'(ifc.out_pold[i]),  32'(e.pold[i]));
            end
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    idle();
    cur = '0;
    // Reset holds off allocation and frees even with requests present.
    op(0, 1, 2, 3, 32);
    ifc.cm_en = 3'b001;
    ifc.cm_dst[0] = 5'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(ifc.out_valid), 0);
    chk("rst_get_en", 32'(ifc.fl_get_en), 0);
    chk("rst_put_en", 32'(ifc.fl_put_en), 0);
    chk("rst_skip", 32'(ifc.fl_rst_skip), 32);
    step();
    rst = 1'b1;

    // 1: single op add x1 <- x2, x3
    step();
    op(0, 1, 2, 3, 32);
    lane(0, 32, 2, 3, 1);
    @(negedge clk);
    chk("t1_in_ready", 32'(ifc.in_ready), 1);
    chk("t1_get_en", 32'(ifc.fl_get_en), 3'b001);
    sb.push_back(cur);

    // Flush back to identity; the group offered this cycle must be refused.
    step();
    ifc.flush = 1'b1;
    op(0, 9, 9, 9, 60);
    @(negedge clk);
    chk("fl_in_ready", 32'(ifc.in_ready), 0);
    chk("fl_get_en", 32'(ifc.fl_get_en), 0);

    // 2: x1<-x5,x6 ; x2<-x1,x1 ; x1<-x2,x3
    step();
    op(0, 1, 5, 6, 32);
    op(1, 2, 1, 1, 33);
    op(2, 1, 2, 3, 34);
    lane(0, 32, 5, 6, 1);
    lane(1, 33, 32, 32, 2);
    lane(2, 34, 33, 3, 32);
    @(negedge clk);
    chk("t2_in_ready", 32'(ifc.in_ready), 1);
    chk("t2_get_en", 32'(ifc.fl_get_en), 3'b111);
    sb.push_back(cur);

    // 3: free list too short for two allocations, then refills
    step();
    ifc.fl_len = fl_len_t'(1);
    op(0, 3, 1, 2, 35);
    op(1, 4, 3, 0, 36);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t3_stall_in_ready", 32'(ifc.in_ready), 0);
      chk("t3_stall_get_en", 32'(ifc.fl_get_en), 0);
      @(posedge clk);
      #1;
    end
    ifc.fl_len = fl_len_t'(2);
    lane(0, 35, 34, 33, 3);
    lane(1, 36, 35, 0, 4);
    @(negedge clk);
    chk("t3_in_ready", 32'(ifc.in_ready), 1);
    chk("t3_get_en", 32'(ifc.fl_get_en), 3'b011);
    sb.push_back(cur);

    // 4: downstream backpressure for three cycles
    step();
    op(0, 5, 4, 1, 37);
    lane(0, 37, 36, 34, 5);
    @(negedge clk);
    chk("t4_in_ready", 32'(ifc.in_ready), 1);
    sb.push_back(cur);
    step();
    op(0, 6, 5, 5, 38);
    ifc.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_hold_in_ready", 32'(ifc.in_ready), 0);
      chk("t4_hold_get_en", 32'(ifc.fl_get_en), 0);
      chk("t4_hold_valid", 32'(ifc.out_valid), 3'b001);
      chk("t4_hold_pdst", 32'(ifc.out_pdst[0]), 37);
      chk("t4_hold_pold", 32'(ifc.out_pold[0]), 5);
      if (k < 2) begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    ifc.out_ready = 1'b1;
    cur = '0;
    lane(0, 38, 37, 37, 6);
    @(negedge clk);
    chk("t4_drain_in_ready", 32'(ifc.in_ready), 1);
    sb.push_back(cur);

    // 5: chained commits of x1 plus a squash, with a flush in the same cycle
    step();
    step();
    ifc.flush = 1'b1;
    ifc.cm_en = 3'b011;
    ifc.cm_dst[0] = 5'd1;
    ifc.cm_pdst[0] = 6'd32;
    ifc.cm_dst[1] = 5'd1;
    ifc.cm_pdst[1] = 6'd34;
    ifc.sq_en = 3'b100;
    ifc.sq_preg[2] = 6'd33;
    op(0, 9, 9, 9, 61);
    @(negedge clk);
    chk("t5_put_en", 32'(ifc.fl_put_en), 3'b111);
    chk("t5_put0", 32'(ifc.fl_put[0]), 1);
    chk("t5_put1", 32'(ifc.fl_put[1]), 32);
    chk("t5_put2", 32'(ifc.fl_put[2]), 33);
    chk("t5_in_ready", 32'(ifc.in_ready), 0);
    chk("t5_get_en", 32'(ifc.fl_get_en), 0);
    step();
    op(0, 7, 1, 2, 39);
    lane(0, 39, 34, 2, 7);
    @(negedge clk);
    chk("t5_post_in_ready", 32'(ifc.in_ready), 1);
    sb.push_back(cur);
    step();
    ifc.cm_en = 3'b001;
    ifc.cm_dst[0] = 5'd1;
    ifc.cm_pdst[0] = 6'd38;
    @(negedge clk);
    chk("t5_cm_put_en", 32'(ifc.fl_put_en), 3'b001);
    chk("t5_cm_put0", 32'(ifc.fl_put[0]), 34);

    // 6: writes to arch 31 (zero register only when RENAME_XZR_EN)
    step();
    op(0, 31, 31, 1, 40);
    op(1, 8, 31, 0, 41);
    ifc.cm_en = 3'b001;
    ifc.cm_dst[0] = 5'd31;
    ifc.cm_pdst[0] = 6'd45;
`ifdef RENAME_XZR_EN
    lane(0, 31, 31, 34, 31);
    lane(1, 41, 31, 0, 8);
    @(negedge clk);
    chk("t6_get_en", 32'(ifc.fl_get_en), 3'b010);
    chk("t6_put_en", 32'(ifc.fl_put_en), 0);
`else
    lane(0, 40, 31, 34, 31);
    lane(1, 41, 40, 0, 8);
    @(negedge clk);
    chk("t6_get_en", 32'(ifc.fl_get_en), 3'b011);
    chk("t6_put_en", 32'(ifc.fl_put_en), 3'b001);
    chk("t6_put0", 32'(ifc.fl_put[0]), 31);
`endif
    sb.push_back(cur);

    // Reset mid-operation restores identity maps and drops the offered group.
    step();
    step();
    rst = 1'b0;
    op(0, 1, 1, 2, 50);
    @(negedge clk);
    chk("t7_rst_get_en", 32'(ifc.fl_get_en), 0);
    step();
    rst = 1'b1;
    op(0, 1, 1, 2, 42);
    lane(0, 42, 1, 2, 1);
    @(negedge clk);
    chk("t7_out_valid", 32'(ifc.out_valid), 0);
    chk("t7_in_ready", 32'(ifc.in_ready), 1);
    sb.push_back(cur);
    step();

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected groups never appeared, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
